// File: rtl/mac_layer_sequencer_if.sv
// Host-side byte stream and result stream of the MAC layer sequencer.
// slave is the sequencer's view; master is the host/consumer view.
interface mac_layer_sequencer_if #(
    parameter int CNT_W = 4
) ();
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      out_result;
    logic [CNT_W-1:0] out_index;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_result, out_index, out_valid
    );

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_result, out_index, out_valid
    );
endinterface

// File: rtl/mac_layer_sequencer.sv
// Sequences a TAPS-lane dot-product MAC over one layer: shared input vector, then one
// weight vector and one result per neuron. Optional ACT_THRESH_EN adds a thresholded ReLU.
module mac_layer_sequencer #(
    parameter int TAPS    = 4,
    parameter int CNT_W   = 4,
    parameter int MAC_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cfg_neurons,
`ifdef ACT_THRESH_EN
    input  logic [17:0]           cfg_thresh,
`endif
    mac_layer_sequencer_if.slave  bus,
    output logic [7:0]            mac_byte,
    output logic                  mac_data_we,
    output logic                  mac_wt_we,
    input  logic [17:0]           mac_result,
    output logic                  busy,
    output logic                  done
);
    localparam int BYTE_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int WAIT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(TAPS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_X, S_LOAD_W, S_WAIT, S_OUT, S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  out_index_q, out_index_d;
    logic [17:0]       out_result_q, out_result_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic [17:0]       act_result;

`ifdef ACT_THRESH_EN
    logic [17:0]       thresh_q, thresh_d;
    assign act_result = (mac_result >= thresh_q) ? mac_result : 18'd0;
`else
    assign act_result = mac_result;
`endif

    // Bytes pass straight through to the MAC; in_ready is only high in the two load
    // states, so the two write enables are mutually exclusive by construction.
    assign accept      = bus.in_valid & in_ready_q;
    assign mac_byte    = bus.in_byte;
    assign mac_data_we = accept & (state_q == S_LOAD_X);
    assign mac_wt_we   = accept & (state_q == S_LOAD_W);

    assign bus.in_ready   = in_ready_q;
    assign bus.out_result = out_result_q;
    assign bus.out_index  = out_index_q;
    assign bus.out_valid  = out_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        count_d      = count_q;
        idx_d        = idx_q;
        out_index_d  = out_index_q;
        out_result_d = out_result_q;
        out_valid_d  = out_valid_q;
`ifdef ACT_THRESH_EN
        thresh_d     = thresh_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d    = cfg_neurons;
                    idx_d      = '0;
                    byte_cnt_d = '0;
`ifdef ACT_THRESH_EN
                    thresh_d   = cfg_thresh;
`endif
                    state_d    = (cfg_neurons == '0) ? S_FIN : S_LOAD_X;
                end
            end
            S_LOAD_X, S_LOAD_W: begin
                if (accept) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        wait_cnt_d = '0;
                        state_d    = (state_q == S_LOAD_X) ? S_LOAD_W : S_WAIT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    out_result_d = act_result;
                    out_index_d  = idx_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                // The input vector stays in the MAC, so the next neuron only reloads weights.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = idx_q + 1'b1;
                    state_d     = (CNT_W'(idx_q + 1'b1) == count_q) ? S_FIN : S_LOAD_W;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD_X) || (state_d == S_LOAD_W);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            out_index_q  <= '0;
            out_result_q <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef ACT_THRESH_EN
            thresh_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            out_index_q  <= out_index_d;
            out_result_q <= out_result_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef ACT_THRESH_EN
            thresh_q     <= thresh_d;
`endif
        end
    end
endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Self-checking bench for mac_layer_sequencer: table of layer vectors with a behavioural
// MAC model, plus hand sequences for reset, idle and mid-layer reset.
`timescale 1ns/1ps
module tb_mac_layer_sequencer;
    localparam int TAPS    = 4;
    localparam int CNT_W   = 4;
    localparam int MAC_LAT = 2;
    localparam int MAX_N   = 3;
    localparam int BUDGET  = 400;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_neurons = '0;
`ifdef ACT_THRESH_EN
    logic [17:0]      cfg_thresh = '0;
`endif
    logic [7:0]       mac_byte;
    logic             mac_data_we, mac_wt_we, busy, done;
    logic [17:0]      mac_result;

    mac_layer_sequencer_if #(.CNT_W(CNT_W)) bus ();

    mac_layer_sequencer #(.TAPS(TAPS), .CNT_W(CNT_W), .MAC_LAT(MAC_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_neurons (cfg_neurons),
`ifdef ACT_THRESH_EN
        .cfg_thresh  (cfg_thresh),
`endif
        .bus         (bus),
        .mac_byte    (mac_byte),
        .mac_data_we (mac_data_we),
        .mac_wt_we   (mac_wt_we),
        .mac_result  (mac_result),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // MAC model: shift registers written in cycle c give a valid mac_result in cycle c+MAC_LAT.
    logic [8*TAPS-1:0] d_sh = '0;
    logic [8*TAPS-1:0] w_sh = '0;
    logic [17:0]       pipe [MAC_LAT] = '{default: '0};

    function automatic logic [17:0] dot(input logic [8*TAPS-1:0] d, input logic [8*TAPS-1:0] w);
        logic [17:0] s;
        s = '0;
        for (int i = 0; i < TAPS; i++) s = s + 18'(d[8*i +: 8]) * 18'(w[8*i +: 8]);
        return s;
    endfunction

    always @(negedge clk) begin
        if (mac_data_we) d_sh <= {d_sh[8*TAPS-9:0], mac_byte};
        if (mac_wt_we)   w_sh <= {w_sh[8*TAPS-9:0], mac_byte};
        pipe[0] <= dot(d_sh, w_sh);
        for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_result = pipe[MAC_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bytes are listed first-sent in the most significant position.
    typedef struct {
        int unsigned n;
        logic [31:0] data;
        logic [31:0] wt  [MAX_N];
        logic [17:0] exp [MAX_N];
        logic [17:0] thresh;
        bit          gaps;
        int unsigned stall;
        bit          poke;
    } vec_t;

    function automatic vec_t mk(input int unsigned n, input logic [31:0] d,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2,
                                input logic [17:0] th, input bit gaps, input int unsigned stall,
                                input bit poke);
        vec_t v;
        v.n = n; v.data = d;
        v.wt[0] = w0; v.wt[1] = w1; v.wt[2] = w2;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        v.thresh = th; v.gaps = gaps; v.stall = stall; v.poke = poke;
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input vec_t v, input int unsigned p);
        int unsigned k, j;
        if (p < TAPS) return v.data[8*(TAPS-1-p) +: 8];
        k = (p - TAPS) / TAPS;
        j = (p - TAPS) % TAPS;
        return v.wt[k][8*(TAPS-1-j) +: 8];
    endfunction

    task automatic run_layer(input vec_t v, input bit chk_lat, input string tag);
        int unsigned total, ptr, got, hold;
        int t, dwe, wwe, bad_we, done_cnt, done_t, ir_seen, ov_seen;
        int stall_bad, lat_bad, last_wt, last_hs, busy_after;
        logic [17:0]      held_res;
        logic [CNT_W-1:0] held_idx;
        logic [3:0]       gap_pat;
        bit prev_ov, after_done, finished;
        total = TAPS + TAPS * v.n;
        ptr = 0; got = 0; hold = v.stall;
        dwe = 0; wwe = 0; bad_we = 0; done_cnt = 0; done_t = -1; ir_seen = 0; ov_seen = 0;
        stall_bad = 0; lat_bad = 0; last_wt = 0; last_hs = 0; busy_after = 0;
        held_res = '0; held_idx = '0; gap_pat = 4'b1001;
        prev_ov = 0; after_done = 0; finished = 0;

`ifdef ACT_THRESH_EN
        cfg_thresh = v.thresh;
`endif
        cfg_neurons   = CNT_W'(v.n);
        start         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        cfg_neurons = ~CNT_W'(v.n);
        t = 1;
        while (!finished && t < BUDGET) begin
            start         = v.poke && (ptr < total);
            bus.in_valid  = (ptr < total) && (!v.gaps || gap_pat[t[1:0]]);
            bus.in_byte   = (ptr < total) ? byte_at(v, ptr) : 8'h00;
            bus.out_ready = (hold == 0);
            @(negedge clk);
            if (mac_data_we) dwe++;
            if (mac_wt_we) begin wwe++; last_wt = t; end
            if ((mac_data_we || mac_wt_we) && !bus.in_valid) bad_we++;
            if (mac_data_we && mac_wt_we) bad_we++;
            if ((mac_data_we || mac_wt_we) && mac_byte !== bus.in_byte) bad_we++;
            if (bus.in_ready) ir_seen++;
            if (bus.in_valid && bus.in_ready) ptr++;
            if (bus.out_valid) begin
                ov_seen++;
                if (!prev_ov) begin
                    held_res = bus.out_result;
                    held_idx = bus.out_index;
                    if (chk_lat && (t - last_wt) != MAC_LAT + 1) lat_bad++;
                end else if (bus.out_result !== held_res || bus.out_index !== held_idx) begin
                    stall_bad++;
                end
                if (!bus.out_ready) begin
                    if (bus.in_ready || mac_data_we || mac_wt_we) stall_bad++;
                    if (hold > 0) hold--;
                end else begin
                    if (got < MAX_N) begin
                        check($sformatf("%s_result%0d", tag, got), 32'(bus.out_result), 32'(v.exp[got]));
                        check($sformatf("%s_index%0d", tag, got), 32'(bus.out_index), got);
                    end
                    got++;
                    last_hs = t;
                end
            end
            prev_ov = bus.out_valid && !bus.out_ready;
            if (after_done) begin
                if (busy) busy_after++;
                finished = 1;
            end
            if (done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
                after_done = 1;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        bus.in_valid = 1'b0;

        check({tag, "_data_writes"}, dwe, (v.n == 0) ? 0 : TAPS);
        check({tag, "_wt_writes"}, wwe, TAPS * v.n);
        check({tag, "_bad_writes"}, bad_we, 0);
        check({tag, "_results"}, got, v.n);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_timing"}, done_t, (v.n == 0) ? 1 : last_hs + 1);
        check({tag, "_busy_after_done"}, busy_after, 0);
        if (v.n == 0) begin
            check({tag, "_in_ready_seen"}, ir_seen, 0);
            check({tag, "_out_valid_seen"}, ov_seen, 0);
        end
        if (chk_lat) check({tag, "_latency"}, lat_bad, 0);
        if (v.stall > 0) begin
            check({tag, "_stall_hold"}, stall_bad, 0);
            check({tag, "_stall_cycles"}, hold, 0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int ptr, wwe, dcnt, bcnt, bad;
        bus.in_byte = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        vecs.push_back(mk(1, 32'h01020304, 32'h05060708, 0, 0, 18'd70, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01010101, 32'h00000000,
                          18'd260100, 18'd1020, 18'd0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 32'h01020304, 32'h05060708, 32'h0A141E28, 0,
                          18'd70, 18'd300, 0, 0, 0, 10, 0));
        vecs.push_back(mk(1, 32'h01020304, 32'h05060708, 0, 0, 18'd70, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h01020304, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 32'hFF000102, 32'h01020304, 32'hC8C8C8C8, 0,
                          18'd266, 18'd51600, 0, 0, 1, 3, 0));
`ifdef ACT_THRESH_EN
        vecs.push_back(mk(1, 32'h01020304, 32'h05060708, 0, 0, 18'd0, 0, 0, 18'd100, 0, 0, 0));
        vecs.push_back(mk(1, 32'h01020304, 32'h05060708, 0, 0, 18'd70, 0, 0, 18'd70, 0, 0, 0));
`endif

        // Reset state, with in_valid asserted to show it is ignored.
        rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_byte = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mac_we", {mac_data_we, mac_wt_we}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle with in_valid high: nothing accepted, nothing written.
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.in_ready || mac_data_we || mac_wt_we || busy) bad++;
            @(posedge clk); #1;
        end
        check("idle_ignores_in_valid", bad, 0);
        bus.in_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_layer(vecs[i], (i == 0), $sformatf("vec%0d", i));

        // Reset part way through LOAD_W abandons the layer without a done pulse.
        cfg_neurons = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ptr = 0; wwe = 0;
        for (int i = 0; i < 20 && wwe < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = 8'(ptr + 1);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) ptr++;
            if (mac_wt_we) wwe++;
            @(posedge clk); #1;
        end
        check("midrst_wt_writes", wwe, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_mac_we", {mac_data_we, mac_wt_we}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus.in_valid = 1'b0;
        dcnt = 0; bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
            @(posedge clk); #1;
        end
        check("midrst_no_done", dcnt, 0);
        check("midrst_stays_idle", bcnt, 0);

        run_layer(vecs[0], 1, "recover");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
